pc_fetch: RTL and testbench

Instruction-fetch front end of the five-stage pipeline; the consumer of the `next_pc`/`flush` redirect produced by the execute-stage PC selector. Holds the architectural fetch PC, issues word fetches to instruction memory over a valid/ready request channel, and delivers `{pc, pc+4, instr}` to the IF/ID boundary. On a redirect it retargets the PC, squashes buffered instructions and discards any in-flight response.

---
 rtl/pc_fetch_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 45 ++++
 rtl/pc_fetch.sv | 119 +++++++++++
 tb/tb_pc_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// +--------------------------------------------------------------------+
// | pc_fetch_pkg: shared types and constants for the fetch front end   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pc_fetch_pkg;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// +--------------------------------------------------------------------+
// | fetch_skid_buf: one-entry pc/instr holding buffer                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_skid_buf
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic        drain,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    fetch_entry_t entry;

    // Load wins over drain so the slot can take the old entry while a new one lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid       <= 1'b1;
            entry.pc    <= load_pc;
            entry.instr <= load_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    assign pc    = entry.pc;
    assign instr = entry.instr;

endmodule

`default_nettype wire

// File: rtl/pc_fetch.sv
// +--------------------------------------------------------------------+
// | pc_fetch: fetch PC, imem request/response handling, IF/ID slot     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_add_4,
    output logic [31:0] if_instr
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic         slot_free;
    logic         rsp_pending_st;
    logic         rsp_in_wait;
    logic         issue;
    logic         handshake;
    logic         rsp_take;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;
    logic         outstanding_next;

    assign slot_free      = !if_valid || if_ready;
    assign rsp_pending_st = (state == S_WAIT) || (state == S_DROP);
    assign rsp_in_wait    = rsp_pending_st && imem_rsp_valid;

    // A response about to be parked in the skid leaves no room for another
    // one, so no new request goes out in that cycle.
    assign issue = !skid_valid &&
                   ((state == S_ISSUE) ||
                    (rsp_in_wait && ((state == S_DROP) || slot_free)));

    assign imem_req_valid   = issue;
    assign imem_req_addr    = fetch_pc;
    assign handshake        = issue && imem_req_ready;
    assign rsp_take         = !flush && (state == S_WAIT) && imem_rsp_valid;
    assign skid_drain       = !flush && slot_free && skid_valid;
    assign skid_load        = rsp_take && (!slot_free || skid_valid);
    assign outstanding_next = handshake || (rsp_pending_st && !imem_rsp_valid);

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .load       (skid_load),
        .drain      (skid_drain),
        .load_pc    (req_pc),
        .load_instr (imem_rsp_data),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_RST;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_pc_add_4 <= '0;
            if_instr    <= '0;
        end else if (state == S_RST) begin
            state <= S_ISSUE;
        end else if (flush) begin
            fetch_pc <= next_pc & 32'hFFFF_FFFC;
            if_valid <= 1'b0;
            state    <= outstanding_next ? S_DROP : S_ISSUE;
        end else begin
            if (handshake) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
                state    <= S_WAIT;
            end else if (rsp_in_wait) begin
                state <= S_ISSUE;
            end

            if (slot_free) begin
                if (skid_valid) begin
                    if_valid    <= 1'b1;
                    if_pc       <= skid_pc;
                    if_pc_add_4 <= skid_pc + 32'd4;
                    if_instr    <= skid_instr;
                end else if (rsp_take) begin
                    if_valid    <= 1'b1;
                    if_pc       <= req_pc;
                    if_pc_add_4 <= req_pc + 32'd4;
                    if_instr    <= imem_rsp_data;
                end else begin
                    if_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// +--------------------------------------------------------------------+
// | tb_pc_fetch: directed self-checking bench for pc_fetch             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc_add_4;
    logic [31:0] if_instr;

    int total = 0;
    int bad   = 0;

    // memory model state
    int          lat;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;

    pc_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc_add_4    (if_pc_add_4),
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: capture handshake before the edge, present any response after it.
    task automatic tick();
        logic        hs;
        logic [31:0] ha;
        #1;
        hs = imem_req_valid && imem_req_ready;
        ha = imem_req_addr;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = ha;
            pend_cnt  = lat;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; next_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if_ready = 1'b1; lat = 1; pend = 1'b0; pend_addr = '0; pend_cnt = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_add_4", if_pc_add_4, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        tick(); tick();
        chk("rst_hold_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // release and stream with zero-wait memory
        rst = 1'b1;
        tick();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        tick();
        chk("stream_addr_4", imem_req_addr, 32'h4);
        chk("stream_if_valid_early", {31'b0, if_valid}, 32'd0);
        tick();
        chk("stream_if_valid", {31'b0, if_valid}, 32'd1);
        chk("stream_if_pc_0", if_pc, 32'h0);
        chk("stream_if_pc_add_4_0", if_pc_add_4, 32'h4);
        chk("stream_if_instr_0", if_instr, mem_word(32'h0));
        chk("stream_addr_8", imem_req_addr, 32'h8);
        tick();
        chk("stream_if_pc_4", if_pc, 32'h4);
        chk("stream_addr_c", imem_req_addr, 32'hC);

        // decode stalls: response for 0x8 parks in the skid
        if_ready = 1'b0;
        #1;
        chk("stall_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        tick(); tick(); tick();
        chk("stall_if_pc", if_pc, 32'h4);
        chk("stall_if_instr", if_instr, mem_word(32'h4));
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        if_ready = 1'b1;
        tick();
        chk("drain_if_pc_8", if_pc, 32'h8);
        chk("drain_if_instr_8", if_instr, mem_word(32'h8));
        chk("drain_req_addr", imem_req_addr, 32'hC);
        tick();
        chk("bubble_if_valid", {31'b0, if_valid}, 32'd0);
        chk("next_req_addr", imem_req_addr, 32'h10);
        lat = 3;
        tick();
        chk("deliver_c", if_pc, 32'hC);
        chk("outstanding_no_req", {31'b0, imem_req_valid}, 32'd0);

        // flush while request to 0x10 is outstanding
        flush = 1'b1; next_pc = 32'h100;
        tick();
        flush = 1'b0;
        chk("flush_if_valid", {31'b0, if_valid}, 32'd0);
        chk("flush_wait_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("drop_req_addr", imem_req_addr, 32'h100);
        lat = 1;
        tick();
        chk("dropped_not_delivered", {31'b0, if_valid}, 32'd0);
        tick();
        chk("redir_if_pc", if_pc, 32'h100);
        chk("redir_if_pc_add_4", if_pc_add_4, 32'h104);
        chk("redir_if_instr", if_instr, mem_word(32'h100));

        // flush coinciding with a response and a handshake; target unaligned
        flush = 1'b1; next_pc = 32'h203;
        tick();
        flush = 1'b0;
        chk("flush2_if_valid", {31'b0, if_valid}, 32'd0);
        chk("flush2_req_addr", imem_req_addr, 32'h200);
        tick();
        chk("flush2_dropped", {31'b0, if_valid}, 32'd0);
        tick();
        chk("flush2_if_pc", if_pc, 32'h200);

        // address wrap at the top of the address space
        flush = 1'b1; next_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        chk("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req_zero", imem_req_addr, 32'h0);
        tick();
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc_add_4", if_pc_add_4, 32'h0);

        // asynchronous reset while a request is outstanding
        rst = 1'b0;
        imem_rsp_valid = 1'b0; pend = 1'b0;
        #1;
        chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_first_req", {31'b0, imem_req_valid}, 32'd1);
        chk("midrst_first_addr", imem_req_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
